reg_file_mp: RTL and testbench

- Parametrised multi-port register file for the pipelined core datapath. Sits between decode (reads) and writeback (writes).
- Adds the following over the single-write, two-read register file:
  - configurable read-port count;
  - two write ports with fixed priority;
  - write-to-read bypass;
  - optional hardwired zero register;
  - per-register pending (scoreboard) bits for hazard detection.

---
 rtl/core_pkg.sv | 9 +
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/reg_file_mp.sv | 86 ++++++++
 tb/tb_reg_file_mp.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared defaults and address types for the core register-file slice.
package core_pkg;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 5;

  typedef logic [DEF_ADDR_WIDTH-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = '0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: set on issue, cleared by writeback, looked up per read port.
module rf_scoreboard
  import core_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en0,
  input  logic [ADDR_WIDTH-1:0]        w_addr0,
  input  logic                         wr_en1,
  input  logic [ADDR_WIDTH-1:0]        w_addr1,
  input  logic                         sb_set,
  input  logic [ADDR_WIDTH-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
  input  logic [NUM_RD-1:0]            fwd_hit,
  output logic [NUM_RD-1:0]            r_busy,
  output logic                         any_busy
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DEPTH-1:0] pending;

  // A new issue outranks a same-edge writeback of the previous producer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (ZERO_REG && (i == 0))
          pending[i] <= 1'b0;
        else if (sb_set && (sb_addr == ADDR_WIDTH'(i)))
          pending[i] <= 1'b1;
        else if ((wr_en0 && (w_addr0 == ADDR_WIDTH'(i))) ||
                 (wr_en1 && (w_addr1 == ADDR_WIDTH'(i))))
          pending[i] <= 1'b0;
      end
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_busy
    assign r_busy[k] = pending[r_addr[k*ADDR_WIDTH +: ADDR_WIDTH]] & ~fwd_hit[k];
  end

  assign any_busy = |pending;
endmodule

// File: rtl/reg_file_mp.sv
// Multi-port register file: two prioritised write ports, N combinational read
// ports with optional write bypass, optional zero register and a scoreboard.
module reg_file_mp
  import core_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int NUM_RD     = 2,
  parameter bit ZERO_REG   = 1'b1,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         wr_en0,
  input  logic [ADDR_WIDTH-1:0]        w_addr0,
  input  logic [DATA_WIDTH-1:0]        w_data0,
  input  logic                         wr_en1,
  input  logic [ADDR_WIDTH-1:0]        w_addr1,
  input  logic [DATA_WIDTH-1:0]        w_data1,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
  output logic [NUM_RD-1:0]            r_busy,
  input  logic                         sb_set,
  input  logic [ADDR_WIDTH-1:0]        sb_addr,
  output logic                         any_busy
);
  localparam int                    DEPTH     = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR = ADDR_WIDTH'(REG_ZERO);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [NUM_RD-1:0]     fwd_hit;
  logic                  wr_ok0, wr_ok1;

  assign wr_ok0 = wr_en0 && !(ZERO_REG && (w_addr0 == ZERO_ADDR));
  assign wr_ok1 = wr_en1 && !(ZERO_REG && (w_addr1 == ZERO_ADDR));

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_ok0) mem[w_addr0] <= w_data0;
      if (wr_ok1) mem[w_addr1] <= w_data1;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    logic [DATA_WIDTH-1:0] rd;
    logic                  hit0, hit1, is_zero;

    assign ra      = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign is_zero = ZERO_REG && (ra == ZERO_ADDR);
    assign hit0    = BYPASS && wr_en0 && (w_addr0 == ra);
    assign hit1    = BYPASS && wr_en1 && (w_addr1 == ra);

    always_comb begin
      rd = mem[ra];
      if (hit0)    rd = w_data0;
      if (hit1)    rd = w_data1;
      if (is_zero) rd = '0;
    end

    assign r_data[k*DATA_WIDTH +: DATA_WIDTH] = rd;
    assign fwd_hit[k] = hit0 | hit1;
  end

  rf_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_RD     (NUM_RD),
    .ZERO_REG   (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en0   (wr_en0),
    .w_addr0  (w_addr0),
    .wr_en1   (wr_en1),
    .w_addr1  (w_addr1),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .r_addr   (r_addr),
    .fwd_hit  (fwd_hit),
    .r_busy   (r_busy),
    .any_busy (any_busy)
  );
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: a bypassing and a non-bypassing instance share stimulus
// and are compared against an array-based reference model.
module tb_reg_file_mp;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        wr_en0, wr_en1, sb_set;
  logic [4:0]  w_addr0, w_addr1, sb_addr;
  logic [31:0] w_data0, w_data1;
  logic [9:0]  r_addr;
  logic [63:0] r_data_b, r_data_n;
  logic [1:0]  r_busy_b, r_busy_n;
  logic        any_b, any_n;

  int checks = 0;
  int passed = 0;

  logic [31:0] mem_m [32];
  logic [31:0] pend_m;

  always #5 clk = ~clk;

  reg_file_mp #(.BYPASS(1'b1)) u_byp (
    .clk(clk), .reset_n(reset_n),
    .wr_en0(wr_en0), .w_addr0(w_addr0), .w_data0(w_data0),
    .wr_en1(wr_en1), .w_addr1(w_addr1), .w_data1(w_data1),
    .r_addr(r_addr), .r_data(r_data_b), .r_busy(r_busy_b),
    .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_b)
  );

  reg_file_mp #(.BYPASS(1'b0)) u_nob (
    .clk(clk), .reset_n(reset_n),
    .wr_en0(wr_en0), .w_addr0(w_addr0), .w_data0(w_data0),
    .wr_en1(wr_en1), .w_addr1(w_addr1), .w_data1(w_data1),
    .r_addr(r_addr), .r_data(r_data_n), .r_busy(r_busy_n),
    .sb_set(sb_set), .sb_addr(sb_addr), .any_busy(any_n)
  );

  // Reference model: register contents and pending flags after each edge.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) mem_m[i] <= '0;
      pend_m <= '0;
    end else begin
      if (wr_en0 && w_addr0 != 5'd0) mem_m[w_addr0] <= w_data0;
      if (wr_en1 && w_addr1 != 5'd0) mem_m[w_addr1] <= w_data1;
      pend_m <= (pend_m & ~((wr_en0 ? (32'd1 << w_addr0) : 32'd0) |
                            (wr_en1 ? (32'd1 << w_addr1) : 32'd0)))
                | (sb_set ? (32'd1 << sb_addr) : 32'd0) & ~32'd1;
    end
  end

  function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (byp && wr_en1 && w_addr1 == a) return w_data1;
    if (byp && wr_en0 && w_addr0 == a) return w_data0;
    return mem_m[a];
  endfunction

  function automatic logic exp_busy(input bit byp, input logic [4:0] a);
    if (a == 5'd0) return 1'b0;
    if (byp && ((wr_en0 && w_addr0 == a) || (wr_en1 && w_addr1 == a))) return 1'b0;
    return pend_m[a];
  endfunction

  task automatic idle();
    wr_en0 = 0; wr_en1 = 0; sb_set = 0;
    w_addr0 = 0; w_addr1 = 0; sb_addr = 0; w_data0 = 0; w_data1 = 0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 0; idle(); r_addr = {5'd5, 5'd1};
    repeat (2) tick();
    #1;
    checks++; if (r_data_b !== 64'd0) $display("FAIL reset r_data got %h exp 0", r_data_b); else passed++;
    checks++; if (r_busy_b !== 2'b00) $display("FAIL reset r_busy got %b exp 00", r_busy_b); else passed++;
    checks++; if (any_b !== 1'b0 || any_n !== 1'b0) $display("FAIL reset any_busy got %b/%b exp 0", any_b, any_n); else passed++;
    reset_n = 1;
    tick();
  endtask

  task automatic test_write_read();
    wr_en0 = 1; w_addr0 = 5; w_data0 = 32'hDEADBEEF;
    tick(); idle(); r_addr = {5'd0, 5'd5}; #1;
    checks++; if (r_data_b[31:0] !== 32'hDEADBEEF) $display("FAIL wr_rd r5 got %h exp deadbeef", r_data_b[31:0]); else passed++;
    checks++; if (r_data_b[63:32] !== 32'd0) $display("FAIL wr_rd r0 got %h exp 0", r_data_b[63:32]); else passed++;
  endtask

  task automatic test_priority();
    tick();
    wr_en0 = 1; w_addr0 = 7; w_data0 = 32'h11;
    wr_en1 = 1; w_addr1 = 7; w_data1 = 32'h22;
    r_addr = {5'd7, 5'd7}; #1;
    checks++; if (r_data_b !== {32'h22, 32'h22}) $display("FAIL prio bypass got %h exp 22/22", r_data_b); else passed++;
    checks++; if (r_data_n[31:0] !== 32'h0) $display("FAIL prio nobyp old got %h exp 0", r_data_n[31:0]); else passed++;
    tick(); idle(); #1;
    checks++; if (r_data_b[31:0] !== 32'h22 || r_data_n[63:32] !== 32'h22) $display("FAIL prio stored got %h/%h exp 22", r_data_b[31:0], r_data_n[63:32]); else passed++;
  endtask

  task automatic test_no_bypass();
    tick();
    wr_en0 = 1; w_addr0 = 3; w_data0 = 32'h5;
    tick(); idle();
    wr_en0 = 1; w_addr0 = 3; w_data0 = 32'h9; r_addr = {5'd0, 5'd3}; #1;
    checks++; if (r_data_n[31:0] !== 32'h5) $display("FAIL nobyp same-cycle got %h exp 5", r_data_n[31:0]); else passed++;
    checks++; if (r_data_b[31:0] !== 32'h9) $display("FAIL byp same-cycle got %h exp 9", r_data_b[31:0]); else passed++;
    tick(); idle(); #1;
    checks++; if (r_data_n[31:0] !== 32'h9) $display("FAIL nobyp next got %h exp 9", r_data_n[31:0]); else passed++;
  endtask

  task automatic test_scoreboard();
    tick();
    sb_set = 1; sb_addr = 9; r_addr = {5'd9, 5'd9};
    tick(); idle(); #1;
    checks++; if (r_busy_b !== 2'b11 || r_busy_n !== 2'b11) $display("FAIL sb set busy got %b/%b exp 11", r_busy_b, r_busy_n); else passed++;
    checks++; if (any_b !== 1'b1) $display("FAIL sb set any got %b exp 1", any_b); else passed++;
    wr_en0 = 1; w_addr0 = 9; w_data0 = 32'h1234; sb_set = 1; sb_addr = 9;
    tick(); idle(); #1;
    checks++; if (r_busy_b !== 2'b11 || any_n !== 1'b1) $display("FAIL sb set-wins got %b/%b exp 11/1", r_busy_b, any_n); else passed++;
    wr_en1 = 1; w_addr1 = 9; w_data1 = 32'h5678; #1;
    checks++; if (r_busy_b !== 2'b00) $display("FAIL sb fwd busy got %b exp 00", r_busy_b); else passed++;
    checks++; if (r_busy_n !== 2'b11) $display("FAIL sb nobyp busy got %b exp 11", r_busy_n); else passed++;
    tick(); idle(); #1;
    checks++; if (r_busy_b !== 2'b00 || any_b !== 1'b0 || any_n !== 1'b0) $display("FAIL sb clear got %b/%b/%b exp 00/0/0", r_busy_b, any_b, any_n); else passed++;
  endtask

  task automatic test_zero_reg();
    tick();
    wr_en0 = 1; w_addr0 = 0; w_data0 = 32'hFFFFFFFF;
    wr_en1 = 1; w_addr1 = 0; w_data1 = 32'hFFFFFFFF;
    sb_set = 1; sb_addr = 0; r_addr = {5'd0, 5'd0}; #1;
    checks++; if (r_data_b !== 64'd0 || r_busy_b !== 2'b00) $display("FAIL zero same-cycle got %h/%b exp 0/00", r_data_b, r_busy_b); else passed++;
    tick(); idle(); #1;
    checks++; if (r_data_b !== 64'd0 || r_data_n !== 64'd0) $display("FAIL zero stored got %h/%h exp 0", r_data_b, r_data_n); else passed++;
    checks++; if (any_b !== 1'b0 || r_busy_n !== 2'b00) $display("FAIL zero busy got %b/%b exp 0/00", any_b, r_busy_n); else passed++;
  endtask

  task automatic test_async_reset();
    tick();
    wr_en0 = 1; w_addr0 = 12; w_data0 = 32'hA5A5A5A5; sb_set = 1; sb_addr = 12;
    tick(); idle(); r_addr = {5'd12, 5'd12}; #1;
    checks++; if (r_data_n[31:0] !== 32'hA5A5A5A5 || any_b !== 1'b1) $display("FAIL areset pre got %h/%b exp a5a5a5a5/1", r_data_n[31:0], any_b); else passed++;
    #2 reset_n = 0; #1;
    checks++; if (r_data_b !== 64'd0 || r_data_n !== 64'd0) $display("FAIL areset data got %h/%h exp 0", r_data_b, r_data_n); else passed++;
    checks++; if (any_b !== 1'b0 || any_n !== 1'b0 || r_busy_b !== 2'b00) $display("FAIL areset busy got %b/%b/%b exp 0", any_b, any_n, r_busy_b); else passed++;
    tick(); reset_n = 1;
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      tick();
      wr_en0  = ($urandom_range(0, 1) == 1);
      wr_en1  = ($urandom_range(0, 2) == 0);
      sb_set  = ($urandom_range(0, 2) == 0);
      w_addr0 = 5'($urandom_range(0, 7));
      w_addr1 = 5'($urandom_range(0, 7));
      sb_addr = 5'($urandom_range(0, 7));
      w_data0 = $urandom;
      w_data1 = $urandom;
      r_addr  = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      #1;
      for (int k = 0; k < 2; k++) begin
        logic [4:0] a;
        a = r_addr[k*5 +: 5];
        checks++; if (r_data_b[k*32 +: 32] !== exp_rd(1'b1, a)) $display("FAIL rnd byp rd%0d a%0d got %h exp %h", k, a, r_data_b[k*32 +: 32], exp_rd(1'b1, a)); else passed++;
        checks++; if (r_data_n[k*32 +: 32] !== exp_rd(1'b0, a)) $display("FAIL rnd nobyp rd%0d a%0d got %h exp %h", k, a, r_data_n[k*32 +: 32], exp_rd(1'b0, a)); else passed++;
        checks++; if (r_busy_b[k] !== exp_busy(1'b1, a)) $display("FAIL rnd byp busy%0d a%0d got %b exp %b", k, a, r_busy_b[k], exp_busy(1'b1, a)); else passed++;
        checks++; if (r_busy_n[k] !== exp_busy(1'b0, a)) $display("FAIL rnd nobyp busy%0d a%0d got %b exp %b", k, a, r_busy_n[k], exp_busy(1'b0, a)); else passed++;
      end
      checks++; if (any_b !== (|pend_m) || any_n !== (|pend_m)) $display("FAIL rnd any_busy got %b/%b exp %b", any_b, any_n, |pend_m); else passed++;
    end
    tick(); idle();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_priority();
    test_no_bypass();
    test_scoreboard();
    test_zero_reg();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
